// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, a per-register busy scoreboard and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W:0]   r_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic [ADDR_W-1:0] w_wa0, w_wa1;
  logic [DATA_W-1:0] w_wd0, w_wd1;
  logic              w_we0, w_we1, w_alloc;
  logic              w_sweep, w_active;
  logic [ADDR_W-1:0] w_clr_idx;

  assign w_wa0     = wr_addr[ADDR_W-1:0];
  assign w_wa1     = wr_addr[2*ADDR_W-1:ADDR_W];
  assign w_wd0     = wr_data[DATA_W-1:0];
  assign w_wd1     = wr_data[2*DATA_W-1:DATA_W];
  assign w_active  = (r_state != S_IDLE);
  assign w_sweep   = (r_state == S_SWEEP);
  assign w_clr_idx = r_idx[ADDR_W-1:0];

  // Requests are dropped while the sequencer owns the array and for a hardwired r0.
  assign w_we0   = wr_en[0] && !w_active && !((ZERO_REG != 0) && (w_wa0 == '0));
  assign w_we1   = wr_en[1] && !w_active && !((ZERO_REG != 0) && (w_wa1 == '0));
  assign w_alloc = alloc_en && !w_active && !((ZERO_REG != 0) && (alloc_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    clr_busy    = 1'b0;
    clr_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) w_state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        clr_busy = 1'b1;
        if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        clr_busy    = 1'b1;
        clr_done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else if ((r_state == S_IDLE) && clr_start) begin
      r_idx <= '0;
    end else if (w_sweep) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // W1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_sweep) begin
      r_mem[w_clr_idx] <= '0;
    end else begin
      if (w_we0) r_mem[w_wa0] <= w_wd0;
      if (w_we1) r_mem[w_wa1] <= w_wd1;
    end
  end

  // Alloc is assigned last: a newly issued producer overrides a retiring write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (w_sweep) begin
      r_busy[w_clr_idx] <= 1'b0;
    end else begin
      if (w_we0)   r_busy[w_wa0]      <= 1'b0;
      if (w_we1)   r_busy[w_wa1]      <= 1'b0;
      if (w_alloc) r_busy[alloc_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rdat;
    logic              w_rbusy;

    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_rdat  = r_mem[w_ra];
      w_rbusy = r_busy[w_ra];
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rdat  = '0;
        w_rbusy = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      if (w_we0 && (w_wa0 == w_ra)) begin
        w_rdat  = w_wd0;
        w_rbusy = alloc_en && (alloc_addr == w_ra);
      end
      if (w_we1 && (w_wa1 == w_ra)) begin
        w_rdat  = w_wd1;
        w_rbusy = alloc_en && (alloc_addr == w_ra);
      end
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_rdat;
    assign rd_busy[k]                  = w_rbusy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: stimulus queues expected outputs, a negedge monitor compares them.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_CLRB = 2;
  localparam int K_CLRD = 3;

  logic             clk;
  logic             rst;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*DW-1:0]  wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             clr_start;
  logic             clr_busy;
  logic             clr_done;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [31:0] mon_act;
  int n_checks = 0;
  int n_err    = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      case (mon_e.kind)
        K_DATA:  mon_act = rd_data[mon_e.port*DW +: DW];
        K_BUSY:  mon_act = {31'b0, rd_busy[mon_e.port]};
        K_CLRB:  mon_act = {31'b0, clr_busy};
        default: mon_act = {31'b0, clr_done};
      endcase
      n_checks++;
      if (mon_act !== mon_e.exp) begin
        n_err++;
        $display("FAIL %s: got %h want %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(input int kind, input int port, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en     = 2'b00;
    alloc_en  = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic set_rd(input int port, input int addr);
    rd_addr[port*AW +: AW] = AW'(addr);
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] d);
    wr_en[port]              = 1'b1;
    wr_addr[port*AW +: AW]   = AW'(addr);
    wr_data[port*DW +: DW]   = d;
  endtask

  // Sweep from the current cycle; r20/r30 are probed to see partial clearing and that a write is dropped.
  task automatic run_sweep(input logic [31:0] v20, input logic [31:0] v30);
    clr_start = 1'b1;
    push(K_CLRB, 0, 0, "clr_busy_start");
    push(K_CLRD, 0, 0, "clr_done_start");
    for (int c = 1; c <= 33; c++) begin
      tick();
      set_rd(0, 30);
      set_rd(1, 20);
      if (c == 1) begin
        wr(0, 30, 32'h00000BAD);
        alloc_en   = 1'b1;
        alloc_addr = 5'd4;
        clr_start  = 1'b1;
      end
      push(K_CLRB, 0, 1, "clr_busy_sweep");
      push(K_CLRD, 0, (c == 33) ? 32'd1 : 32'd0, "clr_done_sweep");
      push(K_DATA, 0, (c >= 32) ? 32'd0 : v30, "sweep_r30");
      push(K_DATA, 1, (c >= 22) ? 32'd0 : v20, "sweep_r20");
    end
    tick();
    push(K_CLRB, 0, 0, "clr_busy_after");
    push(K_CLRD, 0, 0, "clr_done_after");
  endtask

  initial begin
    rst        = 1'b0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    clr_start  = 1'b0;

    // Reset state
    #1;
    set_rd(0, 5);
    set_rd(1, 31);
    push(K_DATA, 0, 0, "rst_data_r5");
    push(K_DATA, 1, 0, "rst_data_r31");
    push(K_BUSY, 0, 0, "rst_busy_r5");
    push(K_CLRB, 0, 0, "rst_clr_busy");
    push(K_CLRD, 0, 0, "rst_clr_done");
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Basic write / read, r0 reads zero
    tick();
    wr(0, 5, 32'hDEADBEEF);
    tick();
    set_rd(0, 5);
    set_rd(1, 0);
    push(K_DATA, 0, 32'hDEADBEEF, "wr_r5");
    push(K_DATA, 1, 0, "rd_r0");

    // Dual-port collision and r0 write
    tick();
    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    tick();
    wr(0, 0, 32'hFFFFFFFF);
    set_rd(0, 7);
    set_rd(1, 0);
    push(K_DATA, 0, 32'h22222222, "w1_wins_r7");
    push(K_DATA, 1, 0, "r0_same_cycle");
    tick();
    set_rd(0, 0);
    push(K_DATA, 0, 0, "r0_after_write");
    push(K_BUSY, 0, 0, "r0_busy");

    // Scoreboard
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    set_rd(0, 9);
    push(K_BUSY, 0, 0, "busy_r9_alloc_cycle");
    tick();
    push(K_BUSY, 0, 1, "busy_r9_set");
    wr(0, 9, 32'h5);
`ifdef REGFILE_BYPASS_EN
    push(K_BUSY, 0, 0, "busy_r9_write_cycle");
`else
    push(K_BUSY, 0, 1, "busy_r9_write_cycle");
`endif
    tick();
    push(K_BUSY, 0, 0, "busy_r9_cleared");
    push(K_DATA, 0, 32'h5, "data_r9");
    wr(1, 9, 32'h6);
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push(K_BUSY, 0, 1, "busy_r9_alloc_wr_cycle");
`else
    push(K_BUSY, 0, 0, "busy_r9_alloc_wr_cycle");
`endif
    tick();
    push(K_BUSY, 0, 1, "busy_r9_alloc_wins");
    push(K_DATA, 0, 32'h6, "data_r9_w1");

    // Same-cycle write then read of r3
    wr(0, 3, 32'h0000ABCD);
    set_rd(1, 3);
`ifdef REGFILE_BYPASS_EN
    push(K_DATA, 1, 32'h0000ABCD, "bypass_r3");
`else
    push(K_DATA, 1, 0, "nobypass_r3");
`endif
    push(K_BUSY, 1, 0, "busy_r3_write_cycle");
    tick();
    push(K_DATA, 1, 32'h0000ABCD, "r3_after");

    // Fill r1..r31 then full sweep
    for (int i = 1; i <= 31; i += 2) begin
      tick();
      wr(0, i, 32'h100 + i);
      if (i + 1 <= 31) wr(1, i + 1, 32'h100 + i + 1);
    end
    tick();
    alloc_en   = 1'b1;
    alloc_addr = 5'd12;
    tick();
    set_rd(0, 12);
    set_rd(1, 31);
    push(K_BUSY, 0, 1, "busy_r12_pre_sweep");
    push(K_DATA, 1, 32'h11F, "fill_r31");
    push(K_DATA, 0, 32'h10C, "fill_r12");
    run_sweep(32'h114, 32'h11E);

    for (int i = 0; i < 16; i++) begin
      tick();
      set_rd(0, i);
      set_rd(1, i + 16);
      push(K_DATA, 0, 0, "post_sweep_data_lo");
      push(K_DATA, 1, 0, "post_sweep_data_hi");
      push(K_BUSY, 0, 0, "post_sweep_busy_lo");
      push(K_BUSY, 1, 0, "post_sweep_busy_hi");
    end

    // Reset during a sweep at idx=10
    tick();
    wr(0, 20, 32'h77);
    wr(1, 30, 32'h99);
    tick();
    clr_start = 1'b1;
    push(K_CLRB, 0, 0, "abort_clr_busy_start");
    for (int c = 1; c <= 10; c++) begin
      tick();
      set_rd(0, 30);
      set_rd(1, 20);
      push(K_CLRB, 0, 1, "abort_clr_busy_sweep");
      push(K_DATA, 0, 32'h99, "abort_r30_pre");
      push(K_DATA, 1, 32'h77, "abort_r20_pre");
    end
    tick();
    rst = 1'b0;
    push(K_CLRB, 0, 0, "abort_clr_busy_rst");
    push(K_CLRD, 0, 0, "abort_clr_done_rst");
    push(K_DATA, 0, 0, "abort_r30_rst");
    push(K_DATA, 1, 0, "abort_r20_rst");
    tick();
    push(K_CLRB, 0, 0, "abort_clr_busy_hold");
    push(K_CLRD, 0, 0, "abort_clr_done_hold");
    @(negedge clk);
    #2;
    rst = 1'b1;
    tick();
    push(K_CLRD, 0, 0, "abort_no_done");
    push(K_CLRB, 0, 0, "abort_idle");
    tick();
    run_sweep(32'h0, 32'h0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file with a per-register scoreboard and a hardware clear sequencer. It serves as the next-generation architectural register file for the pipelined core.
- Configurable data width, depth and read-port count.
- Two write ports, for the WB stage and a late or long-latency writeback.
- Busy bits, so ID-stage hazard detection can stall on registers that are still pending.
- Optional same-cycle write-to-read bypass.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
wr_en  input  2  per-port write enable; bit1 = port W1
wr_addr  input  2*ADDR_W  write addresses, W1 in the upper slice
wr_data  input  2*DATA_W  write data, W1 in the upper slice
rd_addr  input  NUM_RD*ADDR_W  read addresses, port k in slice k
rd_data  output  NUM_RD*DATA_W  read data, port k in slice k
rd_busy  output  NUM_RD  scoreboard busy bit for rd_addr[k]
alloc_en  input  1  mark a destination register pending
alloc_addr  input  ADDR_W  register to mark pending
clr_start  input  1  start a full-file clear sweep
clr_busy  output  1  sweep in progress
clr_done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (rst low, asynchronous):
  - All DEPTH registers and all busy bits go to 0.
  - Sequencer goes to IDLE.
  - clr_busy=0, clr_done=0.
  - rd_data follows the zeroed array, i.e. all zero.
- Writes:
  - Performed on the rising clk edge.
  - When both ports write the same address, W1 wins.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Reads:
  - Combinational, zero latency.
  - rd_data = stored value, or 0 for address 0 when ZERO_REG=1.
  - Without bypass, a value written at edge N is visible after edge N.
- Scoreboard (one busy bit per register):
  - alloc_en sets busy[alloc_addr].
  - Any wr_en clears busy[wr_addr].
  - alloc and write to the same address in the same cycle: alloc wins, busy=1 (a new producer has been issued).
  - busy[0] is held at 0 when ZERO_REG=1.
  - rd_busy[k] = busy[rd_addr[k]], unless modified by the bypass (see Optional Feature).
- Clear sequencer, states IDLE, SWEEP, DONE:
  - IDLE, clr_start=1: go to SWEEP with idx=0.
  - SWEEP: each cycle zero reg[idx], clear busy[idx], idx++. After idx=DEPTH-1, go to DONE.
  - DONE: clr_done=1 for one cycle, then go to IDLE.
  - clr_busy=1 in SWEEP and DONE.
  - Total: clr_start sampled at edge 0; clr_done high in cycle DEPTH+1.
  - While clr_busy=1, wr_en, alloc_en and clr_start are ignored. Reads stay live and return partially cleared contents.
- Widths:
  - idx is ADDR_W+1 bits so the terminal count is detected without wrap.
  - Addresses are used unmodified; no out-of-range case exists.
- Reset mid-sweep: sequencer aborts to IDLE, array is zeroed, no clr_done pulse.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - If wr_en[j]=1, wr_addr[j]=rd_addr[k], the address is non-zero (or ZERO_REG=0), and no sweep is running, then rd_data[k]=wr_data[j] in the same cycle (W1 has priority).
  - In the same hit case, rd_busy[k]=0, unless alloc_en targets the same address in that cycle.
- Not defined:
  - Reads return array contents only.
  - rd_busy is the raw busy bit.
  - No combinational path from wr_* to rd_*.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 via W0; read r5 on port 0 the next cycle -> 0xDEADBEEF. rd_addr=0 -> 0.
2. Same cycle: W0 writes r7=0x11111111, W1 writes r7=0x22222222 -> r7=0x22222222. Writing r0=0xFFFFFFFF -> reads 0.
3. alloc r9 -> rd_busy=1; write r9=0x5 -> busy clears next cycle. alloc r9 plus write r9 in the same cycle -> busy stays 1.
4. With REGFILE_BYPASS_EN: W0 writes r3=0xABCD while port 1 reads r3 in the same cycle -> rd_data=0xABCD, rd_busy=0. Without the macro -> old value.
5. Fill r1..r31, pulse clr_start:
   - clr_busy=1 for 33 cycles; clr_done pulses once at cycle 33.
   - A write during the sweep is ignored.
   - All registers read 0 afterwards.
6. Drop rst during a sweep at idx=10 -> all registers 0, clr_busy=0, no clr_done. A new clr_start after reset release runs the full 33 cycles.
